// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
// Holds the fetch FSM state encoding and the default fetch address step.
package fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int FETCH_ADDR_STEP = 2;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: redirect input, memory request/return, decoder handshake.
// master = fetch_queue side, slave = surrounding pipeline / memory side.
interface fetch_queue_if #(
    parameter int SIZE  = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            redirect;
    logic [SIZE-1:0] redirect_pc;
    logic            mem_req;
    logic [SIZE-1:0] mem_addr;
    logic            mem_gnt;
    logic [SIZE-1:0] mem_rdata;
    logic            instr_valid;
    logic [SIZE-1:0] instr_word;
    logic [SIZE-1:0] instr_pc;
    logic            instr_ready;
    logic [CW-1:0]   count;

    modport master (
        input  redirect, redirect_pc, mem_gnt, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr_word, instr_pc, count
    );

    modport slave (
        output redirect, redirect_pc, mem_gnt, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr_word, instr_pc, count
    );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO used as fetch queue storage (power-of-two depth).
// Ports: clk, rst, flush, push/push_data, pop, head_data, count.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             clr;
    logic             do_push;
    logic             do_pop;

    assign clr     = rst || flush;
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, tags returns with pc.
// Ports: clk, rst, RST_VEC, bus (redirect, mem req/gnt/rdata, instr handshake, count).
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int DEPTH     = 4,
    parameter int ADDR_STEP = FETCH_ADDR_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] RST_VEC,
    fetch_queue_if.master   bus
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t          state;
    logic [SIZE-1:0] fetch_pc;
    logic [SIZE-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   fill;
    logic [2*SIZE-1:0] head;
    logic            room;
    logic            req;
    logic            accept;
    logic            has_head;
    logic            push;
    logic            pop;

    // Outstanding request reserves a slot so its return can never overflow.
    assign room     = (int'(fill) + int'(inflight)) < DEPTH;
    assign req      = !rst && (state == RUN) && room;
    assign accept   = req && bus.mem_gnt;
    assign has_head = !rst && (fill != '0);
    assign push     = inflight && !bus.redirect && !rst;
    assign pop      = has_head && bus.instr_ready && !bus.redirect;

    sync_fifo #(
        .WIDTH (2 * SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (push),
        .push_data ({inflight_pc, bus.mem_rdata}),
        .pop       (pop),
        .head_data (head),
        .count     (fill)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= {RST_VEC[SIZE-1:1], 1'b0};
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect) begin
            // Dropping inflight kills any return, including one granted now.
            state    <= FLUSH;
            fetch_pc <= {bus.redirect_pc[SIZE-1:1], 1'b0};
            inflight <= 1'b0;
        end else begin
            state    <= RUN;
            inflight <= accept;
            if (accept) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + SIZE'(ADDR_STEP);
            end
        end
    end

    assign bus.mem_req     = req;
    assign bus.mem_addr    = fetch_pc;
    assign bus.instr_valid = has_head;
    assign bus.instr_word  = has_head ? head[SIZE-1:0] : '0;
    assign bus.instr_pc    = has_head ? head[2*SIZE-1:SIZE] : '0;
    assign bus.count       = fill;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
// Directed scenarios followed by randomized traffic.
module tb_fetch_queue;

    localparam int SIZE  = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] w;
    } ent_t;

    logic        clk = 0;
    logic        rst;
    logic [15:0] rst_vec;

    fetch_queue_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.SIZE(SIZE), .DEPTH(DEPTH), .ADDR_STEP(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .RST_VEC (rst_vec),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    ent_t        mq[$];
    logic [15:0] m_fpc;
    logic        m_infl;
    logic [15:0] m_infl_pc;
    logic        m_flush;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_req();
        return !rst && !m_flush && ((mq.size() + int'(m_infl)) < DEPTH);
    endfunction

    function automatic logic exp_valid();
        return !rst && (mq.size() > 0);
    endfunction

    task automatic check_model();
        logic        v;
        logic [15:0] w;
        logic [15:0] p;
        v = exp_valid();
        w = v ? mq[0].w : 16'h0;
        p = v ? mq[0].pc : 16'h0;
        chk("mem_req", 32'(bus.mem_req), 32'(exp_req()));
        if (exp_req()) chk("mem_addr", 32'(bus.mem_addr), 32'(m_fpc));
        chk("instr_valid", 32'(bus.instr_valid), 32'(v));
        chk("instr_word", 32'(bus.instr_word), 32'(w));
        chk("instr_pc", 32'(bus.instr_pc), 32'(p));
        if (!rst) chk("count", 32'(bus.count), mq.size());
    endtask

    task automatic update_model();
        logic acc;
        logic pp;
        ent_t e;
        acc = exp_req() && bus.mem_gnt;
        pp  = exp_valid() && bus.instr_ready;
        if (rst) begin
            mq.delete();
            m_fpc   = rst_vec & 16'hFFFE;
            m_infl  = 0;
            m_flush = 0;
        end else if (bus.redirect) begin
            mq.delete();
            m_fpc   = bus.redirect_pc & 16'hFFFE;
            m_infl  = 0;
            m_flush = 1;
        end else begin
            if (pp) void'(mq.pop_front());
            if (m_infl) begin
                e.pc = m_infl_pc;
                e.w  = bus.mem_rdata;
                mq.push_back(e);
            end
            m_flush = 0;
            m_infl  = acc;
            if (acc) begin
                m_infl_pc = m_fpc;
                m_fpc     = m_fpc + 16'd2;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
        bus.mem_rdata = 16'($urandom);
    endtask

    initial begin
        logic [15:0] held;
        bit          hit;
        rst             = 1;
        rst_vec         = 16'hC000;
        bus.redirect    = 0;
        bus.redirect_pc = 0;
        bus.mem_gnt     = 1;
        bus.mem_rdata   = 16'h1234;
        bus.instr_ready = 0;
        mq.delete();
        m_fpc     = 0;
        m_infl    = 0;
        m_infl_pc = 0;
        m_flush   = 0;

        // reset, then fill the queue with no consumer
        cyc();
        cyc();
        rst = 0;
        repeat (5) cyc();
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_req", 32'(bus.mem_req), 32'd0);
        chk("fill_head_pc", 32'(bus.instr_pc), 32'hC000);
        chk("fill_addr", 32'(bus.mem_addr), 32'hC008);

        // drain while refilling
        bus.instr_ready = 1;
        repeat (6) cyc();

        // redirect with a word in flight
        bus.instr_ready = 0;
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (m_infl) hit = 1;
            else cyc();
        end
        chk("inflight_reached", 32'(hit), 32'd1);
        bus.redirect    = 1;
        bus.redirect_pc = 16'hE011;
        cyc();
        bus.redirect = 0;
        chk("redir_count", 32'(bus.count), 32'd0);
        chk("flush_req", 32'(bus.mem_req), 32'd0);
        cyc();
        chk("post_flush_req", 32'(bus.mem_req), 32'd1);
        chk("post_flush_addr", 32'(bus.mem_addr), 32'hE010);

        // grant stall
        bus.mem_gnt = 0;
        repeat (3) cyc();
        chk("stall_addr", 32'(bus.mem_addr), 32'hE010);
        chk("stall_count", 32'(bus.count), 32'd0);

        // address wrap
        bus.mem_gnt     = 1;
        bus.redirect    = 1;
        bus.redirect_pc = 16'hFFFE;
        cyc();
        bus.redirect = 0;
        cyc();
        held = 16'hFFFE;
        chk("wrap_pre", 32'(bus.mem_addr), 32'(held));
        cyc();
        chk("wrap_post", 32'(bus.mem_addr), 32'h0000);

        // reset with three entries and a request in flight
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (mq.size() == 3 && m_infl) hit = 1;
            else cyc();
        end
        chk("count3_reached", 32'(hit), 32'd1);
        rst = 1;
        cyc();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        rst = 0;
        #1;
        chk("rst_addr", 32'(bus.mem_addr), 32'hC000);
        cyc();
        cyc();

        // back-to-back redirects restart the flush
        bus.redirect    = 1;
        bus.redirect_pc = 16'h1235;
        cyc();
        bus.redirect_pc = 16'h2001;
        cyc();
        bus.redirect = 0;
        chk("rr_req", 32'(bus.mem_req), 32'd0);
        cyc();
        chk("rr_addr", 32'(bus.mem_addr), 32'h2000);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            bus.redirect    = ($urandom_range(0, 11) == 0);
            bus.redirect_pc = 16'($urandom);
            bus.mem_gnt     = ($urandom_range(0, 3) != 0);
            bus.instr_ready = $urandom_range(0, 1) == 1;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
